tx_control: RTL and testbench
=============================

TX_CONTROL -- requirements
Module: tx_control

Interface
REQ-001 SHALL have port CLK, input, 1, the system clock; all logic is on its rising edge.
REQ-002 SHALL have port RSTn, input, 1, the asynchronous active-low reset.
REQ-003 SHALL have port Start_Sig, input, 1, a request to send one frame; it is sampled high for one cycle.
REQ-004 SHALL have ports phase_1..phase_4, input, 10 each, the channel phase words to send.
REQ-005 SHALL have port TX_Done_Sig, input, 1, a one-cycle pulse from the UART transmitter when the current byte has been sent.
REQ-006 SHALL have port TX_En_Sig, output, 1, a per-byte send request to the UART transmitter.
REQ-007 SHALL have port TX_Data, output, 8, the byte to send; it is valid while TX_En_Sig=1.
REQ-008 SHALL have port Busy, output, 1, high from the cycle after an accepted Start_Sig until Done_Sig.
REQ-009 SHALL have port Done_Sig, output, 1, a one-cycle pulse when the frame is complete.

Function
REQ-010 SHALL send a frame of 12 bytes, in this order: 0x01, {6'b0,phase_1[9:8]}, phase_1[7:0], 0x02, hi2, lo2, 0x03, hi3, lo3, 0x04, hi4, lo4.
REQ-011 SHALL capture all four phase inputs into internal registers in the cycle Start_Sig is accepted; input changes after capture SHALL NOT affect the frame.
REQ-012 SHALL use an FSM with states IDLE, LOAD, SEND, NEXT and DONE.
REQ-013 SHALL move IDLE to LOAD on Start_Sig=1, capturing the phases and clearing the byte index to 0.
REQ-014 SHALL move LOAD to SEND after exactly one cycle.
REQ-015 SHALL, in SEND, drive TX_En_Sig=1 with TX_Data set to the byte at the current index, holding TX_Data stable until TX_Done_Sig.
REQ-016 SHALL, in SEND with TX_Done_Sig=1, go to NEXT and deassert TX_En_Sig on the following cycle.
REQ-017 SHALL, in NEXT, increment the index and return to SEND if bytes remain, otherwise go to DONE; TX_En_Sig SHALL be low for exactly one cycle between bytes.
REQ-018 SHALL, in DONE, pulse Done_Sig for one cycle, drop Busy and return to IDLE.
REQ-019 SHALL ignore Start_Sig in every state other than IDLE, with no restart and no re-capture.
REQ-020 SHALL ignore TX_Done_Sig in every state other than SEND.
REQ-021 SHALL accept Start_Sig in the IDLE cycle that follows DONE, so frames can be sent back to back.
REQ-022 SHALL set the latency from the Start_Sig cycle to the first TX_En_Sig=1 at 2 cycles.
REQ-023 SHALL keep the byte index 4 bits wide; it never wraps within a frame.

Reset
REQ-024 SHALL, on RSTn=0 at any time, immediately force the FSM to IDLE, the index to 0, TX_En_Sig=0, TX_Data=0x00, Busy=0, Done_Sig=0 and all captured phases to 0.
REQ-025 SHALL, on reset in mid-frame, abandon the frame without a Done_Sig pulse; the next Start_Sig after release starts a complete new frame.

Configuration
REQ-026 SHALL, when macro TX_CHECKSUM_EN is defined, append a 13th byte equal to the XOR of bytes 0-11, using the same handshake as the other bytes.
REQ-027 SHALL, when TX_CHECKSUM_EN is undefined, send 12 bytes with no checksum logic present.

Structure
REQ-028 SHALL put the tag constants 0x01-0x04, the frame length constants (12 and 13) and the FSM state encoding in the shared package tx_control_pkg.
REQ-029 SHALL implement the byte selection (index plus captured phases to byte) as the single combinational sub-module tx_frame_byte_sel; the FSM stays in tx_control.

Verification
REQ-030 SHALL cover: phases 0x155/0x2AA/0x3FF/0x000 and a Start pulse, with TX_Done_Sig returned 5 cycles after each TX_En_Sig rise -> bytes 01 01 55 02 02 AA 03 03 FF 04 00 00, then one Done_Sig pulse.
REQ-031 SHALL cover: the same frame with TX_CHECKSUM_EN defined -> 13th byte 0x04, then Done_Sig.
REQ-032 SHALL cover: Start_Sig re-pulsed during byte 5 and phase_1 changed to 0x000 mid-frame -> the frame is unchanged and exactly one Done_Sig.
REQ-033 SHALL cover: a TX_Done_Sig pulse while IDLE, then a Start -> no advance while IDLE; the first byte sent is 0x01.
REQ-034 SHALL cover: RSTn=0 during byte 7 -> outputs reach reset values without waiting for a clock and no Done_Sig; a new Start after release sends the full frame starting 0x01.
REQ-035 SHALL cover: Start in the IDLE cycle right after Done_Sig -> a second frame starts with a 2-cycle latency.

Source files
------------

// File: rtl/tx_control_pkg.sv
// Shared constants, state encoding and helpers for the tx_control frame sender.
// Optional build macro: TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
package tx_control_pkg;

  localparam int unsigned PHASE_W = 10;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 4;

  localparam logic [BYTE_W-1:0] TAG_1 = 8'h01;
  localparam logic [BYTE_W-1:0] TAG_2 = 8'h02;
  localparam logic [BYTE_W-1:0] TAG_3 = 8'h03;
  localparam logic [BYTE_W-1:0] TAG_4 = 8'h04;

  localparam int unsigned FRAME_LEN_BASE = 12;
  localparam int unsigned FRAME_LEN_CSUM = 13;

`ifdef TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int unsigned FRAME_LEN = CSUM_EN ? FRAME_LEN_CSUM : FRAME_LEN_BASE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [PHASE_W-1:0] p1;
    logic [PHASE_W-1:0] p2;
    logic [PHASE_W-1:0] p3;
    logic [PHASE_W-1:0] p4;
  } phases_t;

  // Upper two phase bits, zero-extended to a byte.
  function automatic logic [BYTE_W-1:0] phase_hi(input logic [PHASE_W-1:0] p);
    return {6'b0, p[9:8]};
  endfunction

  function automatic logic [BYTE_W-1:0] phase_lo(input logic [PHASE_W-1:0] p);
    return p[7:0];
  endfunction

endpackage

// File: rtl/tx_frame_byte_sel.sv
// Maps a frame byte index and the captured phase words to the byte to transmit.
// With TX_CHECKSUM_EN defined, index 12 yields the XOR of bytes 0-11.
module tx_frame_byte_sel
  import tx_control_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  input  phases_t           phases,
  output logic [BYTE_W-1:0] data_c
);

`ifdef TX_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_c;

  always_comb begin
    csum_c = TAG_1 ^ TAG_2 ^ TAG_3 ^ TAG_4
           ^ phase_hi(phases.p1) ^ phase_lo(phases.p1)
           ^ phase_hi(phases.p2) ^ phase_lo(phases.p2)
           ^ phase_hi(phases.p3) ^ phase_lo(phases.p3)
           ^ phase_hi(phases.p4) ^ phase_lo(phases.p4);
  end
`endif

  always_comb begin
    data_c = '0;
    case (idx)
      4'd0:    data_c = TAG_1;
      4'd1:    data_c = phase_hi(phases.p1);
      4'd2:    data_c = phase_lo(phases.p1);
      4'd3:    data_c = TAG_2;
      4'd4:    data_c = phase_hi(phases.p2);
      4'd5:    data_c = phase_lo(phases.p2);
      4'd6:    data_c = TAG_3;
      4'd7:    data_c = phase_hi(phases.p3);
      4'd8:    data_c = phase_lo(phases.p3);
      4'd9:    data_c = TAG_4;
      4'd10:   data_c = phase_hi(phases.p4);
      4'd11:   data_c = phase_lo(phases.p4);
`ifdef TX_CHECKSUM_EN
      4'd12:   data_c = csum_c;
`endif
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/tx_control.sv
// Frame sequencer: captures four phase words on Start_Sig and feeds a UART one byte at a time.
// Optional build macro: TX_CHECKSUM_EN (13-byte frame with trailing XOR checksum).
module tx_control
  import tx_control_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Start_Sig,
  input  logic [PHASE_W-1:0] phase_1,
  input  logic [PHASE_W-1:0] phase_2,
  input  logic [PHASE_W-1:0] phase_3,
  input  logic [PHASE_W-1:0] phase_4,
  input  logic               TX_Done_Sig,
  output logic               TX_En_Sig,
  output logic [BYTE_W-1:0]  TX_Data,
  output logic               Busy,
  output logic               Done_Sig
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  phases_t           phases;
  logic [IDX_W-1:0]  sel_idx_c;
  logic [BYTE_W-1:0] sel_byte_c;

  // In NEXT the byte being loaded belongs to the index about to be stored.
  assign sel_idx_c = (state == ST_NEXT) ? IDX_W'(idx + 1'b1) : idx;

  tx_frame_byte_sel u_byte_sel (
    .idx    (sel_idx_c),
    .phases (phases),
    .data_c (sel_byte_c)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      phases    <= '0;
      TX_En_Sig <= 1'b0;
      TX_Data   <= '0;
      Busy      <= 1'b0;
      Done_Sig  <= 1'b0;
    end else begin
      Done_Sig <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start_Sig) begin
            phases <= {phase_1, phase_2, phase_3, phase_4};
            idx    <= '0;
            Busy   <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          TX_En_Sig <= 1'b1;
          TX_Data   <= sel_byte_c;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (TX_Done_Sig) begin
            TX_En_Sig <= 1'b0;
            state     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          idx <= IDX_W'(idx + 1'b1);
          if (idx == LAST_IDX) begin
            Done_Sig <= 1'b1;
            state    <= ST_DONE;
          end else begin
            TX_En_Sig <= 1'b1;
            TX_Data   <= sel_byte_c;
            state     <= ST_SEND;
          end
        end
        ST_DONE: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_control.sv
// Scoreboard bench for tx_control: frames modelled from phase words, monitor pops per TX_En_Sig rise.
// Honours TX_CHECKSUM_EN to expect the trailing XOR byte.
module tb_tx_control;

`ifdef TX_CHECKSUM_EN
  localparam int FLEN = 13;
`else
  localparam int FLEN = 12;
`endif

  logic       CLK;
  logic       RSTn;
  logic       Start_Sig;
  logic [9:0] phase_1, phase_2, phase_3, phase_4;
  logic       TX_Done_Sig;
  logic       TX_En_Sig;
  logic [7:0] TX_Data;
  logic       Busy;
  logic       Done_Sig;

  logic resp_done;
  logic force_done;
  assign TX_Done_Sig = resp_done | force_done;

  tx_control dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Start_Sig   (Start_Sig),
    .phase_1     (phase_1),
    .phase_2     (phase_2),
    .phase_3     (phase_3),
    .phase_4     (phase_4),
    .TX_Done_Sig (TX_Done_Sig),
    .TX_En_Sig   (TX_En_Sig),
    .TX_Data     (TX_Data),
    .Busy        (Busy),
    .Done_Sig    (Done_Sig)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  int         exp_done;
  int         done_seen;
  int         frame_bytes;
  int         resp_delay;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: tag, high two bits, low byte for each channel, optional XOR.
  task automatic push_frame(input logic [9:0] a, input logic [9:0] b,
                            input logic [9:0] c, input logic [9:0] d);
    int         ph[4];
    logic [7:0] v;
    logic [7:0] x;
    ph[0] = int'(a); ph[1] = int'(b); ph[2] = int'(c); ph[3] = int'(d);
    x = 8'h00;
    for (int ch = 0; ch < 4; ch++) begin
      v = 8'(ch + 1);       exp_q.push_back(v); x ^= v;
      v = 8'(ph[ch] / 256); exp_q.push_back(v); x ^= v;
      v = 8'(ph[ch] % 256); exp_q.push_back(v); x ^= v;
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic monitor_loop();
    logic       prev_en;
    logic [7:0] held;
    int         low_cnt;
    logic [7:0] e;
    prev_en = 1'b0; held = 8'h00; low_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev_en = 1'b0; frame_bytes = 0; low_cnt = 0;
        continue;
      end
      if (TX_En_Sig && !prev_en) begin
        if (frame_bytes > 0) chk("en_gap_cycles", 32'(low_cnt), 32'd1);
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(TX_Data), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(TX_Data), 32'(e));
        end
        held = TX_Data;
        frame_bytes++;
        low_cnt = 0;
      end else if (TX_En_Sig) begin
        chk("data_stable", 32'(TX_Data), 32'(held));
      end else begin
        low_cnt++;
      end
      if (Done_Sig) begin
        chk("done_frame_len", 32'(frame_bytes), 32'(FLEN));
        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
        done_seen++;
        frame_bytes = 0;
      end
      prev_en = TX_En_Sig;
    end
  endtask

  // UART stand-in: answers each byte with a one-cycle done after resp_delay cycles.
  task automatic responder_loop();
    int cnt;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (resp_done) resp_done = 1'b0;
      else if (TX_En_Sig && RSTn) begin
        cnt++;
        if (cnt >= resp_delay) begin
          resp_done = 1'b1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  endtask

  task automatic send_frame(input logic [9:0] a, input logic [9:0] b,
                            input logic [9:0] c, input logic [9:0] d);
    @(negedge CLK);
    phase_1 = a; phase_2 = b; phase_3 = c; phase_4 = d;
    Start_Sig = 1'b1;
    push_frame(a, b, c, d);
    exp_done++;
    @(negedge CLK);
    Start_Sig = 1'b0;
    phase_1 = 10'($urandom); phase_2 = 10'($urandom);
    phase_3 = 10'($urandom); phase_4 = 10'($urandom);
    chk("latency_load_en_low", 32'(TX_En_Sig), 32'd0);
    chk("busy_after_start", 32'(Busy), 32'd1);
    @(negedge CLK);
    chk("latency_first_en", 32'(TX_En_Sig), 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      if (Done_Sig) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      if (frame_bytes >= n) seen = 1'b1;
    end
    if (!seen) chk("byte_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0; exp_done = 0; done_seen = 0; frame_bytes = 0;
    resp_delay = 5; resp_done = 1'b0; force_done = 1'b0;
    RSTn = 1'b0; Start_Sig = 1'b0;
    phase_1 = '0; phase_2 = '0; phase_3 = '0; phase_4 = '0;
    fork
      monitor_loop();
      responder_loop();
    join_none

    repeat (3) @(negedge CLK);
    chk("reset_en", 32'(TX_En_Sig), 32'd0);
    chk("reset_data", 32'(TX_Data), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done_Sig), 32'd0);
    RSTn = 1'b1;

    // Reference frame, UART answering 5 cycles after each request.
    send_frame(10'h155, 10'h2AA, 10'h3FF, 10'h000);
    wait_done();

    // Back-to-back frame started in the IDLE cycle right after Done_Sig.
    resp_delay = 2;
    send_frame(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    wait_done();

    // Stray TX_Done_Sig while idle must not start anything.
    repeat (2) @(negedge CLK);
    force_done = 1'b1;
    @(negedge CLK);
    force_done = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_done_no_en", 32'(TX_En_Sig), 32'd0);
      chk("idle_done_no_busy", 32'(Busy), 32'd0);
    end
    send_frame(10'h155, 10'h2AA, 10'h3FF, 10'h000);
    wait_done();

    // Start re-pulsed mid-frame with a changed phase_1.
    resp_delay = 3;
    send_frame(10'h155, 10'h2AA, 10'h3FF, 10'h000);
    wait_bytes(5);
    @(negedge CLK);
    Start_Sig = 1'b1; phase_1 = 10'h000;
    @(negedge CLK);
    Start_Sig = 1'b0;
    wait_done();
    repeat (6) @(negedge CLK);
    chk("single_done", 32'(done_seen), 32'(exp_done));
    chk("idle_busy_low", 32'(Busy), 32'd0);

    // Asynchronous reset during byte 7 abandons the frame.
    send_frame(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    wait_bytes(7);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    chk("async_rst_en", 32'(TX_En_Sig), 32'd0);
    chk("async_rst_data", 32'(TX_Data), 32'd0);
    chk("async_rst_busy", 32'(Busy), 32'd0);
    chk("async_rst_done", 32'(Done_Sig), 32'd0);
    exp_q.delete();
    exp_done--;
    repeat (3) @(negedge CLK);
    chk("no_done_on_reset", 32'(done_seen), 32'(exp_done));
    RSTn = 1'b1;
    resp_delay = 5;
    send_frame(10'h155, 10'h2AA, 10'h3FF, 10'h000);
    wait_done();

    // Random phases and UART latencies.
    for (int i = 0; i < 8; i++) begin
      resp_delay = int'($urandom_range(1, 6));
      send_frame(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
      wait_done();
      repeat (int'($urandom_range(0, 3))) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    chk("total_done_count", 32'(done_seen), 32'(exp_done));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
